mux_to_leds: RTL and testbench
==============================

# mux_to_leds

Registered 2:1 bus multiplexer that drives board LEDs from two switch/data buses. It sits between raw board inputs (switches, buttons) and the LED pins. Inputs pass through synchronizers. The select input is optionally debounced, and the chosen bus is presented on a registered output. An indicator output shows which bus is currently selected.

## Interface
- N, default 4: bus width of i_a, i_b, o_y; legal range 1..32.
- SYNC_STAGES, default 2: synchronizer depth on all inputs; legal 0..4; 0 = no synchronizer.
- DEBOUNCE, default 0: consecutive cycles a new select level must persist before it is accepted; 0 = no debounce; legal 0..2^20.

Ports:
- i_clk  input  1  single system clock; all logic on rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_a  input  N  data bus A, selected when effective select = 0.
- i_b  input  N  data bus B, selected when effective select = 1.
- i_sel  input  1  raw select, asynchronous to i_clk (switch/button).
- o_y  output  N  registered mux result to LEDs.
- o_sel  output  1  registered effective select (indicator LED).

## Operation
- Synchronizer: each bit of i_a, i_b and i_sel passes through a chain of SYNC_STAGES flops. Call the outputs a_s, b_s, sel_s.
- With SYNC_STAGES = 0, a_s/b_s/sel_s are the raw inputs.
- Debounce (DEBOUNCE > 0):
  - Counter cnt, width clog2(DEBOUNCE+1), plus register sel_eff.
  - If sel_s == sel_eff: cnt <= 0.
  - Else, if cnt == DEBOUNCE-1: sel_eff <= sel_s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE cycles never changes sel_eff.
  - Any return to sel_eff's level restarts the count.
- Debounce (DEBOUNCE = 0): sel_eff is sel_s; no counter or register is generated.
- Output register, each cycle:
  - o_y <= sel_eff ? b_s : a_s.
  - o_sel <= sel_eff.
- Data buses are synchronized but not debounced. Multi-bit skew across one cycle is acceptable for LED use.
- Reset while i_rst=1, on every edge:
  - All synchronizer flops, cnt, sel_eff, o_y and o_sel go to 0.
  - Inputs are ignored.
- After reset: o_y = 0 and o_sel = 0, i.e. bus A is selected.
- Reset has priority over all other updates. Reset asserted mid-debounce discards the partial count.

## Timing
- Data latency (input stable before edge k to o_y updated after edge k+SYNC_STAGES): SYNC_STAGES+1 rising edges. Defaults: 3 cycles.
- Select latency with DEBOUNCE=0: SYNC_STAGES+1 cycles, both to o_y and to o_sel.
- Select latency with DEBOUNCE=D>0: SYNC_STAGES+D+1 cycles from a stable new i_sel level to o_sel/o_y switching.
- Simultaneous data and select change: o_y shows the new select with the data synchronized in the same cycle. No intermediate mixing within a bit.
- Release of reset: the first edge with i_rst=0 starts loading the synchronizers. o_y reflects inputs SYNC_STAGES+1 edges later.
- All outputs come straight from flops; no combinational path from any input to any output.

## Structure
- No shared package required. Parameters are local to the block.
- Optional shared constant (if a project package exists): LED_BUS_WIDTH default 4.
- One natural sub-module, sync_bit_chain: SYNC_STAGES-deep single-bit synchronizer with synchronous active-high reset. Instantiate it N+N+1 times via generate.
- The debounce counter and the mux/output register stay in the top module.

## Test plan
- Reset, defaults (N=4, SYNC_STAGES=2, DEBOUNCE=0): i_a=4'hF, i_b=4'h5, i_sel=1, hold i_rst=1 for 4 cycles.
  - Required: o_y=0 and o_sel=0 throughout.
  - Required: 3 cycles after release, o_y=4'h5 and o_sel=1.
- Select A: i_sel=0, i_a=4'h9, i_b=4'h6 -> after 3 cycles, o_y=4'h9 and o_sel=0.
- Select B: change i_sel to 1 -> after 3 cycles, o_y=4'h6.
- Random: 8 iterations, each toggling i_sel with random i_a/i_b and holding 4 cycles.
  - Required: o_y equals the selected bus after latency.
  - Required: compare against a delayed reference model.
- Debounce (DEBOUNCE=5):
  - 4-cycle high pulse on i_sel -> o_sel stays 0.
  - 5-cycle hold -> o_sel=1 exactly SYNC_STAGES+6 cycles after the i_sel rise.
- Reset mid-debounce (DEBOUNCE=5): assert i_rst after 3 cycles of a pending change -> o_sel=0.
  - Required: after release, a full 5-cycle hold is again needed before o_sel changes.
- SYNC_STAGES=0: change i_a (with i_sel=0) -> o_y updates after exactly 1 edge.

Source files
------------

// File: rtl/mux_to_leds_pkg.sv
// Shared constants and helpers for the LED bus multiplexer.
package mux_to_leds_pkg;

  localparam int unsigned LED_BUS_WIDTH = 4;

  // Width of a counter that must hold values 0..d, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned d);
    int unsigned w;
    w = $clog2(d + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_to_leds_sync_bit_chain.sv
// Single-bit synchronizer: STAGES flops in series, synchronous active-high reset.
// With STAGES = 0 the input passes straight through.
module sync_bit_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  if (STAGES == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_chain
    logic [STAGES-1:0] r_chain;

    // Shift the raw bit through the chain; reset clears every stage.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_chain <= '0;
      end else begin
        r_chain[0] <= i_d;
        for (int i = 1; i < int'(STAGES); i++) begin
          r_chain[i] <= r_chain[i-1];
        end
      end
    end

    assign o_q = r_chain[STAGES-1];
  end

endmodule

// File: rtl/mux_to_leds.sv
// Registered 2:1 bus multiplexer driving board LEDs from two synchronized
// input buses, with an optionally debounced select and a select indicator.
module mux_to_leds
  import mux_to_leds_pkg::*;
#(
  parameter int unsigned N           = LED_BUS_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sel,
  output logic [N-1:0] o_y,
  output logic         o_sel
);

  logic [N-1:0] w_a_s;
  logic [N-1:0] w_b_s;
  logic         w_sel_s;
  logic         w_sel_eff;

  logic [N-1:0] r_y;
  logic         r_sel;

  // One synchronizer per bit of each data bus, plus one for the select.
  for (genvar g = 0; g < int'(N); g++) begin : g_sync_data
    sync_bit_chain #(.STAGES(SYNC_STAGES)) u_sync_a (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_a[g]),
      .o_q   (w_a_s[g])
    );
    sync_bit_chain #(.STAGES(SYNC_STAGES)) u_sync_b (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_b[g]),
      .o_q   (w_b_s[g])
    );
  end

  sync_bit_chain #(.STAGES(SYNC_STAGES)) u_sync_sel (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_sel),
    .o_q   (w_sel_s)
  );

  if (DEBOUNCE == 0) begin : g_no_debounce
    assign w_sel_eff = w_sel_s;
  end else begin : g_debounce
    localparam int unsigned   CNT_W    = cnt_width(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sel_eff;

    // Accept a new select level only after it persists DEBOUNCE cycles;
    // any return to the current level restarts the count.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_cnt     <= '0;
        r_sel_eff <= 1'b0;
      end else if (w_sel_s == r_sel_eff) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_sel_eff <= w_sel_s;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_sel_eff = r_sel_eff;
  end

  // Output register: chosen bus and select indicator, straight from flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y   <= '0;
      r_sel <= 1'b0;
    end else begin
      r_y   <= w_sel_eff ? w_b_s : w_a_s;
      r_sel <= w_sel_eff;
    end
  end

  assign o_y   = r_y;
  assign o_sel = r_sel;

endmodule

// File: tb/tb_mux_to_leds.sv
// Bench for mux_to_leds: three instances (defaults, DEBOUNCE=5, SYNC_STAGES=0)
// share one stimulus stream; a history-based model predicts the undebounced ones.
module tb_mux_to_leds;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = 4'h0;
  logic [3:0] b   = 4'h0;
  logic       sel = 1'b0;

  logic [3:0] y0, y1, y2;
  logic       s0, s1, s2;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int HMAX = 4096;
  logic hist_rst [HMAX];
  logic hist_sel [HMAX];
  logic [3:0] hist_a [HMAX];
  logic [3:0] hist_b [HMAX];
  int n_edges = 0;

  always #5 clk = ~clk;

  mux_to_leds #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_sel(sel), .o_y(y0), .o_sel(s0));
  mux_to_leds #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(5)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_sel(sel), .o_y(y1), .o_sel(s1));
  mux_to_leds #(.N(4), .SYNC_STAGES(0), .DEBOUNCE(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_sel(sel), .o_y(y2), .o_sel(s2));

  // Record what every rising edge saw on the inputs.
  always @(posedge clk) begin
    if (n_edges < HMAX) begin
      hist_rst[n_edges] = rst;
      hist_sel[n_edges] = sel;
      hist_a[n_edges]   = a;
      hist_b[n_edges]   = b;
    end
    n_edges = n_edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Without debounce, the output after edge k is the mux of the inputs seen at
  // edge k-s, unless a reset edge fell anywhere in k-s..k (pipeline still zero).
  function automatic logic [4:0] model(input int s, input int k);
    logic       ms;
    logic [3:0] my;
    if (k - s < 0) return 5'h00;
    for (int j = k - s; j <= k; j++) begin
      if (hist_rst[j]) return 5'h00;
    end
    ms = hist_sel[k-s];
    my = ms ? hist_b[k-s] : hist_a[k-s];
    return {ms, my};
  endfunction

  // Advance one edge, sample just after it, and check the undebounced instances.
  task automatic tick();
    int k;
    logic [4:0] e0, e2;
    @(posedge clk);
    #1;
    k = n_edges - 1;
    e0 = model(2, k);
    e2 = model(0, k);
    check("m0_y",   32'(y0), 32'(e0[3:0]));
    check("m0_sel", 32'(s0), 32'(e0[4]));
    check("m2_y",   32'(y2), 32'(e2[3:0]));
    check("m2_sel", 32'(s2), 32'(e2[4]));
  endtask

  initial begin
    // Reset with inputs active: outputs held at zero throughout.
    rst = 1'b1; a = 4'hF; b = 4'h5; sel = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_y",   32'(y0), 32'h0);
      check("rst_sel", 32'(s0), 32'h0);
      check("rst_sel_db", 32'(s1), 32'h0);
    end
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_y",   32'(y0), 32'h5);
    check("post_rst_sel", 32'(s0), 32'h1);

    // Select A.
    sel = 1'b0; a = 4'h9; b = 4'h6;
    repeat (3) tick();
    check("selA_y",   32'(y0), 32'h9);
    check("selA_sel", 32'(s0), 32'h0);

    // Select B.
    sel = 1'b1;
    repeat (3) tick();
    check("selB_y",   32'(y0), 32'h6);
    check("selB_sel", 32'(s0), 32'h1);

    // Random toggling with random buses.
    for (int it = 0; it < 8; it++) begin
      sel = ~sel;
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      repeat (4) tick();
      check("rnd_y",   32'(y0), 32'(sel ? b : a));
      check("rnd_sel", 32'(s0), 32'(sel));
    end

    // Zero-stage instance follows a data change after a single edge.
    sel = 1'b0; tick();
    a = ~a;
    tick();
    check("nosync_y", 32'(y2), 32'(a));

    // Debounce: settle on select 0.
    sel = 1'b0;
    repeat (12) tick();
    check("db_settle", 32'(s1), 32'h0);

    // A 4-cycle pulse never gets accepted.
    sel = 1'b1;
    repeat (4) tick();
    sel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("db_glitch", 32'(s1), 32'h0);
    end

    // A held level switches the indicator on exactly the 8th edge.
    b = 4'hA;
    sel = 1'b1;
    repeat (7) tick();
    check("db_hold_early", 32'(s1), 32'h0);
    tick();
    check("db_hold_sel", 32'(s1), 32'h1);
    check("db_hold_y",   32'(y1), 32'hA);

    // Return to select 0 and settle.
    sel = 1'b0;
    repeat (12) tick();
    check("db_back", 32'(s1), 32'h0);

    // Reset three cycles into a pending change discards the count.
    sel = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("db_midrst_sel", 32'(s1), 32'h0);
    check("db_midrst_y",   32'(y1), 32'h0);
    rst = 1'b0;
    repeat (7) tick();
    check("db_rehold_early", 32'(s1), 32'h0);
    tick();
    check("db_rehold_sel", 32'(s1), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
